rsa_decrypt_engine: RTL and testbench

Sequential RSA decryption engine. It computes m = c^d mod n by left-to-right square-and-multiply, using a bit-serial interleaved modular multiplier. It sits at the receive end of the letter link and consumes ciphertext words produced by the combinational encryptor. Words arrive over a valid/ready stream, and one plaintext word is returned per accepted ciphertext.

---
 rtl/rsa_pkg.sv | 15 +
 rtl/rsa_decrypt_engine_if.sv | 29 ++
 rtl/rsa_decrypt_engine_mod_mul.sv | 68 ++++++
 rtl/rsa_decrypt_engine.sv | 167 ++++++++++++++++
 tb/tb_rsa_decrypt_engine.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA decryption engine.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        SQR   = 3'd2,
        MUL   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int RSA_WIDTH = 26;
    localparam int ONE       = 1;

endpackage

// File: rtl/rsa_decrypt_engine_if.sv
// Ciphertext-in / plaintext-out stream bundle for the RSA decryption engine.
interface rsa_decrypt_engine_if
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_cipher;
    logic [WIDTH-1:0] key_d;
    logic [WIDTH-1:0] key_n;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_plain;
    logic             out_err;
    logic             busy;

    modport master (
        output in_valid, in_cipher, key_d, key_n, out_ready,
        input  in_ready, out_valid, out_plain, out_err, busy
    );

    modport slave (
        input  in_valid, in_cipher, key_d, key_n, out_ready,
        output in_ready, out_valid, out_plain, out_err, busy
    );

endinterface

// File: rtl/rsa_decrypt_engine_mod_mul.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n in WIDTH cycles.
module mod_mul_serial
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);

    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] n_q;
    logic [CW-1:0]    cnt;

    // acc < n and a < n keep 2*acc + a below 3n, so two conditional subtracts suffice
    function automatic logic [AW-1:0] mod_step(input logic [AW-1:0]    acc_in,
                                               input logic             bit_in,
                                               input logic [WIDTH-1:0] a_in,
                                               input logic [WIDTH-1:0] n_in);
        logic [AW-1:0] t;
        logic [AW-1:0] n_ext;
        n_ext = {2'b00, n_in};
        t     = (acc_in << 1) + (bit_in ? {2'b00, a_in} : '0);
        if (t >= n_ext) t = t - n_ext;
        if (t >= n_ext) t = t - n_ext;
        return t;
    endfunction

    // the start cycle already processes the multiplier MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            a_q  <= '0;
            b_sh <= '0;
            n_q  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (start) begin
            a_q  <= a;
            n_q  <= n;
            b_sh <= b << 1;
            acc  <= mod_step('0, b[WIDTH-1], a, n);
            cnt  <= CW'(WIDTH - 1);
            done <= (WIDTH == 1);
        end else if (cnt != '0) begin
            acc  <= mod_step(acc, b_sh[WIDTH-1], a_q, n_q);
            b_sh <= b_sh << 1;
            cnt  <= cnt - CW'(1);
            done <= (cnt == CW'(1));
        end else begin
            done <= 1'b0;
        end
    end

    assign p = acc[WIDTH-1:0];

endmodule

// File: rtl/rsa_decrypt_engine.sv
// RSA decryption engine, m = c^d mod n by left-to-right square-and-multiply.
// Build option CONST_TIME_EN: run MUL for every exponent bit (fixed latency).
//
// state | meaning
// IDLE  | ready for a ciphertext word
// CHECK | validate n >= 2 and c < n, initialise r and bit index
// SQR   | r = r*r mod n on the shared multiplier
// MUL   | r = r*c mod n on the shared multiplier
// DONE  | result held until out_ready
module rsa_decrypt_engine
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input logic                  clk,
    input logic                  rst_n,
    rsa_decrypt_engine_if.slave  bus
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] p;
    logic [IW-1:0]    idx;
    logic             err_q;
    logic             first;
    logic             settle;
    logic             mul_start;
    logic             mul_done;
    logic             idx_dec;
    logic             accept;
    logic             operands_bad;
    logic             last_bit;
    logic             out_valid_int;

    assign accept        = (state == IDLE) && bus.in_valid;
    assign operands_bad  = (n_q < WIDTH'(2)) || (c_q >= n_q);
    assign last_bit      = (idx == '0);
    // error results pay the same one-cycle DONE entry as computed results
    assign out_valid_int = (state == DONE) && !settle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        mul_start  = 1'b0;
        op_a       = r;
        op_b       = r;
        r_next     = r;
        idx_dec    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) state_next = CHECK;
            end
            CHECK: begin
                state_next = operands_bad ? DONE : SQR;
            end
            SQR: begin
                if (first) begin
                    mul_start = 1'b1;
                end else if (mul_done) begin
                    r_next = p;
`ifdef CONST_TIME_EN
                    state_next = MUL;
                    mul_start  = 1'b1;
                    op_a       = p;
                    op_b       = c_q;
`else
                    if (d_q[idx]) begin
                        state_next = MUL;
                        mul_start  = 1'b1;
                        op_a       = p;
                        op_b       = c_q;
                    end else if (last_bit) begin
                        state_next = DONE;
                    end else begin
                        idx_dec   = 1'b1;
                        mul_start = 1'b1;
                        op_a      = p;
                        op_b      = p;
                    end
`endif
                end
            end
            MUL: begin
                if (mul_done) begin
`ifdef CONST_TIME_EN
                    r_next = d_q[idx] ? p : r;
`else
                    r_next = p;
`endif
                    if (last_bit) begin
                        state_next = DONE;
                    end else begin
                        state_next = SQR;
                        idx_dec    = 1'b1;
                        mul_start  = 1'b1;
                        op_a       = r_next;
                        op_b       = r_next;
                    end
                end
            end
            DONE: begin
                if (out_valid_int && bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q    <= '0;
            d_q    <= '0;
            n_q    <= '0;
            r      <= '0;
            idx    <= '0;
            err_q  <= 1'b0;
            first  <= 1'b0;
            settle <= 1'b0;
        end else begin
            first  <= (state == CHECK) && !operands_bad;
            settle <= (state == CHECK) && operands_bad;
            if (accept) begin
                c_q <= bus.in_cipher;
                d_q <= bus.key_d;
                n_q <= bus.key_n;
            end
            if (state == CHECK) begin
                r     <= operands_bad ? '0 : WIDTH'(ONE);
                err_q <= operands_bad;
                idx   <= IW'(WIDTH - 1);
            end else begin
                r <= r_next;
                if (idx_dec) idx <= idx - IW'(1);
            end
        end
    end

    mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (op_a),
        .b     (op_b),
        .n     (n_q),
        .done  (mul_done),
        .p     (p)
    );

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_int;
    assign bus.busy      = (state != IDLE);
    assign bus.out_plain = out_valid_int ? r : '0;
    assign bus.out_err   = out_valid_int && err_q;

endmodule

// File: tb/tb_rsa_decrypt_engine.sv
// Randomised bench for rsa_decrypt_engine at WIDTH=8 against a plain-arithmetic modexp model.
// Latency expectations follow CONST_TIME_EN when it is defined.
module tb_rsa_decrypt_engine;

    localparam int W       = 8;
    localparam int LAT_MAX = 2 * W * W + 20;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rsa_decrypt_engine_if #(.WIDTH(W)) bus ();

    rsa_decrypt_engine #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // right-to-left binary exponentiation, independent of the engine's scan order
    function automatic longint ref_modexp(input longint c, input longint d, input longint n);
        longint res, base, e;
        res  = 1;
        base = c % n;
        e    = d;
        while (e > 0) begin
            if (e % 2 == 1) res = (res * base) % n;
            base = (base * base) % n;
            e    = e / 2;
        end
        return res % n;
    endfunction

    function automatic longint ref_err(input longint c, input longint n);
        return (n < 2 || c >= n) ? 1 : 0;
    endfunction

    function automatic longint ref_plain(input longint c, input longint d, input longint n);
        return (ref_err(c, n) != 0) ? 0 : ref_modexp(c, d, n);
    endfunction

    function automatic longint ref_lat(input longint c, input longint d, input longint n);
        logic [W-1:0] dv;
        dv = W'(d);
        if (ref_err(c, n) != 0) return 2;
`ifdef CONST_TIME_EN
        return 2 * W * W + 2;
`else
        return W * (W + $countones(dv)) + 2;
`endif
    endfunction

    // in_valid stays high with scrambled operands while busy: they must be ignored
    task automatic do_op(input longint c, input longint d, input longint n, input int stall,
                         output longint plain, output longint err, output int lat);
        int           guard;
        logic [W-1:0] hold_plain;
        logic         hold_err;
        plain = 0;
        err   = 0;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_wait", longint'(bus.in_ready), 1);
        bus.in_cipher = W'(c);
        bus.key_d     = W'(d);
        bus.key_n     = W'(n);
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_cipher = W'($urandom);
        bus.key_d     = W'($urandom);
        bus.key_n     = W'($urandom);
        chk("busy_after_accept", longint'({bus.in_ready, bus.busy}), 1);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!bus.out_valid && lat < LAT_MAX);
        bus.in_valid = 1'b0;
        chk("out_valid_seen", longint'(bus.out_valid), 1);
        if (!bus.out_valid) return;
        hold_plain = bus.out_plain;
        hold_err   = bus.out_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_hold", longint'({bus.out_valid, bus.in_ready, bus.out_err, bus.out_plain}),
                longint'({1'b1, 1'b0, hold_err, hold_plain}));
        end
        plain         = longint'(hold_plain);
        err           = longint'(hold_err);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("ready_after_handshake", longint'({bus.in_ready, bus.out_valid}), 2);
    endtask

    task automatic run_check(input string tag, input longint c, input longint d, input longint n,
                             input int stall);
        longint plain, err;
        int     lat;
        do_op(c, d, n, stall, plain, err, lat);
        chk({tag, "_plain"}, plain, ref_plain(c, d, n));
        chk({tag, "_err"}, err, ref_err(c, n));
        chk({tag, "_lat"}, longint'(lat), ref_lat(c, d, n));
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint plain, err, c, n, d;
        int     lat;

        bus.in_valid  = 1'b0;
        bus.in_cipher = '0;
        bus.key_d     = '0;
        bus.key_n     = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", longint'(bus.in_ready), 1);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_out_plain", longint'(bus.out_plain), 0);
        chk("rst_out_err", longint'(bus.out_err), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        rst_n = 1'b1;

        do_op(32, 5, 35, 0, plain, err, lat);
        chk("basic_plain", plain, 2);
        chk("basic_err", err, 0);
`ifdef CONST_TIME_EN
        chk("basic_lat", longint'(lat), 130);
`else
        chk("basic_lat", longint'(lat), 82);
`endif

        for (int m = 0; m < 26; m++) begin
            c = ref_modexp(longint'(m), 5, 35);
            do_op(c, 5, 35, 0, plain, err, lat);
            chk("sweep_roundtrip", plain, longint'(m));
            chk("sweep_lat", longint'(lat), ref_lat(c, 5, 35));
        end

        do_op(40, 5, 35, 0, plain, err, lat);
        chk("c_ge_n_err", err, 1);
        chk("c_ge_n_plain", plain, 0);
        chk("c_ge_n_lat", longint'(lat), 2);
        run_check("n_one", 0, 5, 1, 0);
        run_check("n_zero", 3, 7, 0, 1);
        run_check("c_eq_n", 35, 5, 35, 0);

        run_check("d_zero", 12, 0, 35, 0);
        run_check("c_zero", 0, 5, 35, 0);
        run_check("stall20", 32, 5, 35, 20);

        for (int k = 0; k < 25; k++) begin
            n = longint'($urandom_range(2, (1 << W) - 1));
            if ($urandom_range(0, 7) == 0) c = longint'($urandom_range(0, (1 << W) - 1));
            else                           c = longint'($urandom_range(0, 32'(n - 1)));
            d = longint'($urandom_range(0, (1 << W) - 1));
            run_check("random", c, d, n, int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        bus.in_cipher = W'(100);
        bus.key_d     = W'(255);
        bus.key_n     = W'(251);
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_op_busy", longint'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", longint'(bus.in_ready), 1);
        chk("abort_out_valid", longint'(bus.out_valid), 0);
        chk("abort_out_plain", longint'(bus.out_plain), 0);
        chk("abort_out_err", longint'(bus.out_err), 0);
        chk("abort_busy", longint'(bus.busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_check("after_abort", 32, 5, 35, 0);
        run_check("after_abort_big", 100, 255, 251, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
